// File: rtl/fc_input_feeder.sv
// FC-layer input feeder: streams an activation vector, fetches the matching weight row per
// activation, presents aligned pairs with start_FC, then waits out the PE drain and pulses done.
module fc_input_feeder #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int DATA_WIDTH     = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
    parameter int parallel_fc_PE = 32,
    parameter int N_INPUTS       = 120,
    parameter int ADDR_WIDTH     = 7,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 go,
    output logic                                 busy,
    output logic                                 done,
    input  logic [DATA_WIDTH-1:0]                s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [ADDR_WIDTH-1:0]                w_addr,
    output logic                                 w_rd_en,
    input  logic [DATA_WIDTH*parallel_fc_PE-1:0] w_rd_data,
    output logic [DATA_WIDTH-1:0]                input_fc,
    output logic [DATA_WIDTH*parallel_fc_PE-1:0] weightCaches_fc,
    output logic                                 start_FC,
    output logic [ADDR_WIDTH-1:0]                elem_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0]      DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q;
    logic             accept, last_accept, drain_end;

    // Handshake: a word transfers on a rising edge where s_valid && s_ready; s_valid may
    // be held or dropped freely, s_ready is registered and never depends on s_valid.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        last_accept = 1'b0;
        drain_end   = 1'b0;
        case (state_q)
            IDLE: begin
                // done marks the cycle just after leaving DRAIN; go there is not a new request
                if (go && !done) state_d = LOAD;
            end
            LOAD: begin
                accept      = s_valid && s_ready;
                last_accept = accept && (elem_count == LAST_IDX);
                if (last_accept) state_d = DRAIN;
            end
            DRAIN: begin
                drain_end = (drain_cnt_q == DRAIN_LAST);
                if (drain_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The row read now returns next cycle, exactly when the registered activation is shown.
    assign w_rd_en         = accept;
    assign w_addr          = elem_count;
    assign weightCaches_fc = w_rd_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            s_ready     <= 1'b0;
            input_fc    <= '0;
            start_FC    <= 1'b0;
            elem_count  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            done     <= drain_end;
            start_FC <= accept;
            if (accept) begin
                input_fc   <= s_data;
                elem_count <= elem_count + ADDR_WIDTH'(1);
            end
            case (state_q)
                IDLE: begin
                    if (state_d == LOAD) begin
                        busy       <= 1'b1;
                        s_ready    <= 1'b1;
                        elem_count <= '0;
                    end
                end
                LOAD: begin
                    if (last_accept) s_ready <= 1'b0;
                end
                DRAIN: begin
                    // first DRAIN cycle carries the last start_FC, so counting starts there
                    if (drain_end) begin
                        busy        <= 1'b0;
                        drain_cnt_q <= '0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_input_feeder.sv
// Directed bench for fc_input_feeder: reset, full-rate and stalled passes, ignored go,
// mid-pass reset and back-to-back passes, checked against a scoreboard of expected pairs.
module tb_fc_input_feeder;

    localparam int DW = 32;
    localparam int PE = 4;
    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DR = 2;
    localparam int RW = DW * PE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          go = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          busy, done, s_ready, w_rd_en, start_fc;
    logic [AW-1:0] w_addr, elem_count;
    logic [RW-1:0] w_rd_data = '0;
    logic [RW-1:0] weight_caches_fc;
    logic [DW-1:0] input_fc;

    fc_input_feeder #(
        .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .DATA_WIDTH(DW), .parallel_fc_PE(PE),
        .N_INPUTS(N), .ADDR_WIDTH(AW), .DRAIN_CYCLES(DR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .w_addr(w_addr), .w_rd_en(w_rd_en), .w_rd_data(w_rd_data),
        .input_fc(input_fc), .weightCaches_fc(weight_caches_fc),
        .start_FC(start_fc), .elem_count(elem_count)
    );

    // clock / weight RAM (row k holds word k+1 in every PE slot)
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (w_rd_en) w_rd_data <= {PE{DW'(32'(w_addr) + 1)}};
    end

    // 1.0, 2.0, 3.0, 4.0 as float32
    logic [DW-1:0] act_tab [N] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_idx  = 0;
    int go_cyc   = 0;
    int done_cnt = 0;
    int last_done_cyc  = 0;
    int last_start_cyc = 0;

    logic [DW-1:0] exp_q[$];
    logic [RW-1:0] exp_row_q[$];
    int            exp_cyc_q[$];
    int            rel_q[$];

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // monitor + scoreboard, evaluated at the falling edge of every cycle
    task automatic sample();
        logic [DW-1:0] k1;
        if (s_valid && s_ready) begin
            check("w_rd_en_on_accept", w_rd_en, 1);
            check("w_addr", w_addr, acc_idx);
            k1 = DW'(acc_idx + 1);
            exp_q.push_back(act_tab[acc_idx]);
            exp_row_q.push_back({PE{k1}});
            exp_cyc_q.push_back(cyc + 1);
            acc_idx++;
        end else begin
            check("w_rd_en_idle", w_rd_en, 0);
        end
        if (start_fc) begin
            check("start_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("input_fc", input_fc, exp_q.pop_front());
                check("weight_row", weight_caches_fc, exp_row_q.pop_front());
                check("start_cycle", cyc, exp_cyc_q.pop_front());
            end
            rel_q.push_back(cyc - go_cyc);
            last_start_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // one full pass; pat gives s_valid per cycle (1 beyond pat_len), go_busy pokes go while busy
    task automatic run_pass(input logic [15:0] pat, input int pat_len, input bit go_busy);
        int p = 0;
        int guard = 0;
        int d0;
        acc_idx = 0;
        go = 1'b1;
        go_cyc = cyc;
        step();
        go = 1'b0;
        while (acc_idx < N && guard < 100) begin
            s_valid = (p < pat_len) ? pat[p] : 1'b1;
            s_data  = act_tab[acc_idx];
            go      = go_busy && (p == 2);
            p++;
            guard++;
            step();
        end
        s_valid = 1'b0;
        go = 1'b0;
        check("accept_count", acc_idx, N);
        d0 = done_cnt;
        guard = 0;
        while (done_cnt == d0 && guard < 20) begin
            go = go_busy;
            guard++;
            step();
        end
        go = 1'b0;
        check("done_seen", done_cnt - d0, 1);
        check("done_latency", last_done_cyc - last_start_cyc, DR);
        check("elem_count_final", elem_count, N);
        check("done_pulse_width", done, 0);
        check("idle_after_done", busy, 0);
        check("pairs_all_presented", exp_q.size(), 0);
    endtask

    initial begin
        int d0;
        int guard;
        int rel_a[$];

        // reset with go and s_valid asserted
        go = 1'b1;
        s_valid = 1'b1;
        s_data = 32'hDEAD_BEEF;
        repeat (3) begin
            step();
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_s_ready", s_ready, 0);
            check("rst_start", start_fc, 0);
            check("rst_input_fc", input_fc, 0);
            check("rst_elem_count", elem_count, 0);
            check("rst_w_rd_en", w_rd_en, 0);
        end
        rst_n = 1'b1;
        go = 1'b0;
        s_valid = 1'b0;
        step();
        check("idle_no_ready", s_ready, 0);

        // full-rate pass
        run_pass(16'h0000, 0, 1'b0);

        // stalls: s_valid 1,0,0,1,1,0,1
        run_pass(16'h0059, 7, 1'b0);

        // go while busy (LOAD, DRAIN and the done cycle)
        run_pass(16'h0005, 3, 1'b1);

        // reset after two accepts
        acc_idx = 0;
        go = 1'b1;
        go_cyc = cyc;
        step();
        go = 1'b0;
        guard = 0;
        while (acc_idx < 2 && guard < 20) begin
            s_valid = 1'b1;
            s_data  = act_tab[acc_idx];
            guard++;
            step();
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        d0 = done_cnt;
        check("abort_start", start_fc, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", s_ready, 0);
        check("abort_elem_count", elem_count, 0);
        check("abort_input_fc", input_fc, 0);
        repeat (6) step();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_pairs", exp_q.size(), 0);
        run_pass(16'h0000, 0, 1'b0);

        // back-to-back passes: second go in the cycle after done
        rel_q.delete();
        run_pass(16'h0000, 0, 1'b0);
        rel_a = rel_q;
        rel_q.delete();
        run_pass(16'h0000, 0, 1'b0);
        check("b2b_len", rel_q.size(), rel_a.size());
        for (int i = 0; i < rel_a.size() && i < rel_q.size(); i++) begin
            check("b2b_start_offset", rel_q[i], rel_a[i]);
        end
        check("b2b_first_offset", (rel_q.size() > 0) ? rel_q[0] : -1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
